q_5_9_decoder: RTL and testbench



---
 rtl/q_5_9_pkg.sv | 43 ++++
 rtl/q_5_9_word_packer.sv | 51 +++++
 rtl/q_5_9_decoder.sv | 95 +++++++++
 tb/tb_q_5_9_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/q_5_9_pkg.sv
// Shared q_5_9 state codes, decoder FSM states and the transition classifier
// used to recover the FSM's x input from consecutive state samples.
package q_5_9_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } q_state_t;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic vld;
    logic bit_val;
    logic ambig;
    logic illegal;
  } dec_t;

  // S3->S1 is reachable from both x values, so the bit is reported as ambiguous.
  function automatic dec_t decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_t d;
    d = '0;
    case ({prev, cur})
      {S0, S0}, {S1, S0}, {S2, S2}: d.vld = 1'b1;
      {S0, S3}, {S1, S2}, {S2, S3}: begin
        d.vld     = 1'b1;
        d.bit_val = 1'b1;
      end
      {S3, S1}: begin
        d.vld   = 1'b1;
        d.ambig = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/q_5_9_word_packer.sv
// LSB-first bit packer with a one-entry valid/ready word buffer; word appears one cycle after its last bit.
// Backpressure: a word completing into a full, unaccepted buffer is dropped and sets sticky overrun.
module q_5_9_word_packer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_vld,
  input  logic              in_bit,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              done;
  logic              accept;

  // Shifting in at the MSB leaves the first bit of the word in bit 0 once full.
  assign sr_nxt = {in_bit, sr[DATA_W-1:1]};
  assign done   = in_vld && (cnt == CNT_W'(DATA_W - 1));
  assign accept = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr         <= '0;
      cnt        <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (in_vld) begin
        sr  <= sr_nxt;
        cnt <= done ? '0 : cnt + 1'b1;
      end
      if (done && (!word_valid || accept)) begin
        word_data  <= sr_nxt;
        word_valid <= 1'b1;
      end else begin
        if (done) overrun <= 1'b1;
        if (accept) word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/q_5_9_decoder.sv
// Recovers q_5_9 x bits from sampled state codes (1-cycle registered pulses) and packs them into words.
// Word output is valid/ready with one-entry buffer; optional counters under Q_5_9_DEC_STATS_EN.
module q_5_9_decoder
  import q_5_9_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter logic AMBIG_FILL = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        y_in,
  input  logic              y_valid,
  output logic              x_out,
  output logic              x_valid,
  output logic              x_ambig,
  output logic              err_illegal,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun,
  output logic [7:0]        err_cnt,
  output logic [7:0]        ambig_cnt
);

  dec_state_t state;
  dec_state_t state_nxt;
  logic [1:0] prev;
  dec_t       dec;
  logic       bit_val;

  always_ff @(posedge clk) begin
    if (!rstn) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dec       = '0;
    if (y_valid) begin
      if (state == SYNC) state_nxt = TRACK;
      else               dec       = decode(prev, y_in);
    end
    bit_val = dec.ambig ? AMBIG_FILL : dec.bit_val;
  end

  // prev always follows the sample, which is also how an illegal pair resyncs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev        <= 2'b00;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      x_ambig     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      x_out       <= bit_val;
      x_valid     <= dec.vld;
      x_ambig     <= dec.ambig;
      err_illegal <= dec.illegal;
      if (y_valid) prev <= y_in;
    end
  end

  q_5_9_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .in_vld     (dec.vld),
    .in_bit     (bit_val),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun)
  );

`ifdef Q_5_9_DEC_STATS_EN
  logic [7:0] err_q;
  logic [7:0] amb_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= '0;
      amb_q <= '0;
    end else begin
      if (dec.illegal && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (dec.ambig && amb_q != 8'hFF)   amb_q <= amb_q + 8'd1;
    end
  end

  assign err_cnt   = err_q;
  assign ambig_cnt = amb_q;
`else
  assign err_cnt   = '0;
  assign ambig_cnt = '0;
`endif

endmodule

// File: tb/tb_q_5_9_decoder.sv
// Directed bench: three decoder instances (DATA_W=4 fill 0, DATA_W=4 fill 1, DATA_W=2 fill 0).
module tb_q_5_9_decoder;

  localparam logic [1:0] Y0 = 2'b00, Y1 = 2'b01, Y2 = 2'b10, Y3 = 2'b11;
`ifdef Q_5_9_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rstn_ab, yv_ab, rdy_ab;
  logic [1:0] y_ab;
  logic       rstn_c, yv_c, rdy_c;
  logic [1:0] y_c;

  logic       a_x, a_xv, a_amb, a_ill, a_wv, a_ovr;
  logic [3:0] a_wd;
  logic [7:0] a_ec, a_ac;
  logic       b_x, b_xv, b_amb, b_ill, b_wv, b_ovr;
  logic [3:0] b_wd;
  logic [7:0] b_ec, b_ac;
  logic       c_x, c_xv, c_amb, c_ill, c_wv, c_ovr;
  logic [1:0] c_wd;
  logic [7:0] c_ec, c_ac;

  q_5_9_decoder #(.DATA_W(4), .AMBIG_FILL(1'b0)) u_a (
    .clk(clk), .rstn(rstn_ab), .y_in(y_ab), .y_valid(yv_ab),
    .x_out(a_x), .x_valid(a_xv), .x_ambig(a_amb), .err_illegal(a_ill),
    .word_data(a_wd), .word_valid(a_wv), .word_ready(rdy_ab), .overrun(a_ovr),
    .err_cnt(a_ec), .ambig_cnt(a_ac)
  );

  q_5_9_decoder #(.DATA_W(4), .AMBIG_FILL(1'b1)) u_b (
    .clk(clk), .rstn(rstn_ab), .y_in(y_ab), .y_valid(yv_ab),
    .x_out(b_x), .x_valid(b_xv), .x_ambig(b_amb), .err_illegal(b_ill),
    .word_data(b_wd), .word_valid(b_wv), .word_ready(rdy_ab), .overrun(b_ovr),
    .err_cnt(b_ec), .ambig_cnt(b_ac)
  );

  q_5_9_decoder #(.DATA_W(2), .AMBIG_FILL(1'b0)) u_c (
    .clk(clk), .rstn(rstn_c), .y_in(y_c), .y_valid(yv_c),
    .x_out(c_x), .x_valid(c_xv), .x_ambig(c_amb), .err_illegal(c_ill),
    .word_data(c_wd), .word_valid(c_wv), .word_ready(rdy_c), .overrun(c_ovr),
    .err_cnt(c_ec), .ambig_cnt(c_ac)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp_ab(input logic [1:0] y);
    y_ab = y; yv_ab = 1'b1;
    tick();
    yv_ab = 1'b0;
  endtask

  task automatic samp_c(input logic [1:0] y);
    y_c = y; yv_c = 1'b1;
    tick();
    yv_c = 1'b0;
  endtask

  initial begin
    rstn_ab = 1'b0; yv_ab = 1'b0; y_ab = Y0; rdy_ab = 1'b1;
    rstn_c  = 1'b0; yv_c  = 1'b0; y_c  = Y0; rdy_c  = 1'b0;
    repeat (2) tick();
    chk("rst_a_flags", {a_x, a_xv, a_amb, a_ill, a_wv, a_ovr}, 0);
    chk("rst_a_word", a_wd, 0);
    chk("rst_a_cnts", {a_ec, a_ac}, 0);
    chk("rst_c_flags", {c_x, c_xv, c_amb, c_ill, c_wv, c_ovr, c_wd}, 0);
    rstn_ab = 1'b1; rstn_c = 1'b1;

    // Main stream: bits 0,1,amb,1,0,1,amb,0
    samp_ab(Y0);
    chk("sync_no_bit", {a_xv, a_amb, a_ill}, 0);
    samp_ab(Y0);
    chk("t1", {a_xv, a_x, a_amb}, 3'b100);
    samp_ab(Y3);
    chk("t2", {a_xv, a_x, a_amb}, 3'b110);
    samp_ab(Y1);
    chk("t3_a", {a_xv, a_x, a_amb}, 3'b101);
    chk("t3_b", {b_xv, b_x, b_amb}, 3'b111);
    samp_ab(Y2);
    chk("t4", {a_xv, a_x, a_amb}, 3'b110);
    chk("w1_a", {a_wv, a_wd}, {1'b1, 4'hA});
    chk("w1_b", {b_wv, b_wd}, {1'b1, 4'hE});
    samp_ab(Y2);
    chk("t5", {a_xv, a_x}, 2'b10);
    chk("w1_acc", a_wv, 0);
    samp_ab(Y3);
    chk("t6", {a_xv, a_x}, 2'b11);
    samp_ab(Y1);
    chk("t7", {a_xv, a_amb}, 2'b11);
    samp_ab(Y0);
    chk("t8", {a_xv, a_x, a_amb}, 3'b100);
    chk("w2_a", {a_wv, a_wd}, {1'b1, 4'h2});
    chk("w2_b", {b_wv, b_wd}, {1'b1, 4'h6});
    chk("ambig_cnt", a_ac, STATS ? 32'd2 : 32'd0);
    tick();
    chk("idle_pulses", {a_xv, a_amb, a_ill, a_wv}, 0);

    // Illegal S0->S1 then resync: S1->S2 decodes as 1
    samp_ab(Y1);
    chk("ill_pulse", {a_ill, a_xv}, 2'b10);
    samp_ab(Y2);
    chk("resync_bit", {a_ill, a_xv, a_x}, 3'b011);

    // Reset with 3 bits pending in the packer
    samp_ab(Y2);
    samp_ab(Y3);
    chk("pre_rst_xv", a_xv, 1);
    rstn_ab = 1'b0;
    tick();
    chk("mid_rst_out", {a_x, a_xv, a_amb, a_ill, a_wv, a_ovr, a_wd}, 0);
    rstn_ab = 1'b1;
    samp_ab(Y0);
    chk("post_rst_sync", {a_xv, a_ill}, 0);
    samp_ab(Y3);
    samp_ab(Y1);
    samp_ab(Y0);
    chk("post_rst_partial", a_wv, 0);
    samp_ab(Y0);
    chk("post_rst_word_a", {a_wv, a_wd}, {1'b1, 4'h1});
    chk("post_rst_word_b", {b_wv, b_wd}, {1'b1, 4'h3});

    // Backpressure on DATA_W=2 instance
    samp_c(Y0);
    samp_c(Y0);
    samp_c(Y3);
    chk("bp_w1", {c_wv, c_wd, c_ovr}, {1'b1, 2'b10, 1'b0});
    samp_c(Y1);
    samp_c(Y0);
    chk("bp_hold", {c_wv, c_wd}, {1'b1, 2'b10});
    chk("bp_overrun", c_ovr, 1);
    rdy_c = 1'b1;
    tick();
    chk("bp_accept", {c_wv, c_ovr}, 2'b01);
    tick();
    chk("bp_sticky", c_ovr, 1);

    // Simultaneous accept and complete
    rstn_c = 1'b0; rdy_c = 1'b0;
    tick();
    chk("c_rst_ovr", c_ovr, 0);
    rstn_c = 1'b1;
    samp_c(Y0);
    samp_c(Y0);
    samp_c(Y3);
    samp_c(Y1);
    chk("sim_full", {c_wv, c_wd}, {1'b1, 2'b10});
    rdy_c = 1'b1;
    samp_c(Y0);
    chk("sim_load", {c_wv, c_wd, c_ovr}, {1'b1, 2'b00, 1'b0});
    tick();
    chk("sim_drain", {c_wv, c_ovr}, 0);

    // Saturating illegal count: S1->S1 is illegal every sample
    rstn_ab = 1'b0;
    tick();
    rstn_ab = 1'b1;
    samp_ab(Y1);
    for (int i = 0; i < 300; i++) samp_ab(Y1);
    chk("err_last", a_ill, 1);
    chk("err_cnt_sat", a_ec, STATS ? 32'd255 : 32'd0);
    chk("ambig_cnt_clr", a_ac, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
